// File: rtl/lfsr_prpg_core.sv
// lfsr_prpg_core
//   Instruction-driven pseudo-random pattern generator. A WIDTH-bit LFSR is
//   stepped in Galois or Fibonacci form under a programmable tap mask. The
//   core runs one shift per clock for multi-cycle RUN/BATCH instructions.
//   BATCH captures each new state into a pattern RAM with a wrapping address.
//   Every shift records its Hamming distance and accumulates statistics, and
//   a sequential restoring divider writes the average distance back to RAM.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   instr_valid/instr   instruction offer {opcode[21:16], operand[15:0]}
//   instr_ready         high when an offered instruction will be accepted
//   busy                a RUN/BATCH/ST_AVG operation is in progress
//   halted              HALT executed; only reset leaves this state
//   illegal             sticky flag for undefined opcodes
//   lfsr_q / lfsr_next  current state and combinational next state
//   addr                pattern RAM pointer
//   last_hd             Hamming distance of the most recent shift
//   dbg_addr / dbg_data combinational debug read port into the RAM
module lfsr_prpg_core #(
  parameter int WIDTH     = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 24,
  parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAP_RST  = WIDTH'(8'h1D)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  input  logic [21:0]                  instr,
  output logic                         instr_ready,
  output logic                         busy,
  output logic                         halted,
  output logic                         illegal,
  output logic [WIDTH-1:0]             lfsr_q,
  output logic [WIDTH-1:0]             lfsr_next,
  output logic [ADDR_W-1:0]            addr,
  output logic [$clog2(WIDTH+1)-1:0]   last_hd,
  input  logic [ADDR_W-1:0]            dbg_addr,
  output logic [WIDTH-1:0]             dbg_data
);

  localparam int HD_W = $clog2(WIDTH+1);

  localparam logic [5:0] OP_CFG_TAP   = 6'h01;
  localparam logic [5:0] OP_INIT      = 6'h02;
  localparam logic [5:0] OP_RUN       = 6'h03;
  localparam logic [5:0] OP_STORE     = 6'h04;
  localparam logic [5:0] OP_LOAD      = 6'h05;
  localparam logic [5:0] OP_INIT_ADDR = 6'h06;
  localparam logic [5:0] OP_ADD_ADDR  = 6'h07;
  localparam logic [5:0] OP_CFG_MODE  = 6'h08;
  localparam logic [5:0] OP_ST_HD     = 6'h09;
  localparam logic [5:0] OP_ST_AVG    = 6'h0A;
  localparam logic [5:0] OP_BATCH     = 6'h0B;
  localparam logic [5:0] OP_HALT      = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_BATCH, S_DIV, S_WR, S_HALT
  } state_t;

  // One LFSR step; tap[0] only matters in Fibonacci form.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] tap,
                                                 input logic             fib);
    logic [WIDTH-1:0] n;
    if (fib) begin
      n = {s[WIDTH-2:0], ^(s & tap)};
    end else begin
      n[0] = s[WIDTH-1];
      for (int i = 1; i < WIDTH; i++) begin
        n[i] = s[i-1] ^ (tap[i] & s[WIDTH-1]);
      end
    end
    return n;
  endfunction

  function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [HD_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + HD_W'(v[i]);
    end
    return c;
  endfunction

  // Statistics stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_lfsr;
  logic [WIDTH-1:0]   r_tap;
  logic               r_mode;
  logic [ADDR_W-1:0]  r_addr;
  logic [HD_W-1:0]    r_last_hd;
  logic [CNT_W-1:0]   r_hd_sum;
  logic [CNT_W-1:0]   r_shift_cnt;
  logic               r_illegal;
  logic [15:0]        r_cnt;
  logic [CNT_W-1:0]   r_quo;
  logic [CNT_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_dsr;
  logic [WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic [5:0]         w_opcode;
  logic [15:0]        w_operand;
  logic               w_accept;
  logic [WIDTH-1:0]   w_next;
  logic [HD_W-1:0]    w_hd;
  logic [CNT_W:0]     w_div_shift;
  logic               w_div_ge;
  logic [CNT_W-1:0]   w_div_diff;
  logic [WIDTH-1:0]   w_avg;
  logic               w_mem_we;
  logic [WIDTH-1:0]   w_mem_wd;

  assign w_opcode  = instr[21:16];
  assign w_operand = instr[15:0];
  assign w_accept  = instr_valid && instr_ready;
  assign w_next    = lfsr_step(r_lfsr, r_tap, r_mode);
  assign w_hd      = popcount(r_lfsr ^ w_next);

  // Restoring divider: bring in the next dividend bit, subtract if it fits.
  // The partial remainder is always below the divisor, so the difference
  // fits in CNT_W bits whenever the subtraction is taken.
  assign w_div_shift = {r_rem, r_quo[CNT_W-1]};
  assign w_div_ge    = w_div_shift >= {1'b0, r_dsr};
  assign w_div_diff  = w_div_shift[CNT_W-1:0] - r_dsr;
  // A zero divisor would produce an all-ones quotient; report 0 instead.
  assign w_avg       = (r_dsr == '0) ? '0 : r_quo[WIDTH-1:0];

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_opcode)
            OP_RUN:    if (w_operand != 16'd0) w_state_nxt = S_RUN;
            OP_BATCH:  if (w_operand != 16'd0) w_state_nxt = S_BATCH;
            OP_ST_AVG: w_state_nxt = S_DIV;
            OP_HALT:   w_state_nxt = S_HALT;
            default:   w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_RUN, S_BATCH: if (r_cnt == 16'd1) w_state_nxt = S_IDLE;
      S_DIV:          if (r_cnt == 16'd1) w_state_nxt = S_WR;
      S_WR:           w_state_nxt = S_IDLE;
      S_HALT:         w_state_nxt = S_HALT;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy        = (r_state == S_RUN) || (r_state == S_BATCH) ||
                  (r_state == S_DIV) || (r_state == S_WR);
    halted      = (r_state == S_HALT);
    instr_ready = !busy && !halted;
  end

  // ---- Datapath registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr      <= SEED_RST;
      r_tap       <= TAP_RST;
      r_mode      <= 1'b0;
      r_addr      <= '0;
      r_last_hd   <= '0;
      r_hd_sum    <= '0;
      r_shift_cnt <= '0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (w_opcode)
              OP_CFG_TAP:   r_tap  <= w_operand[WIDTH-1:0];
              OP_CFG_MODE:  r_mode <= w_operand[0];
              OP_INIT: begin
                r_lfsr      <= w_operand[WIDTH-1:0];
                r_last_hd   <= '0;
                r_hd_sum    <= '0;
                r_shift_cnt <= '0;
              end
              OP_RUN, OP_BATCH: r_cnt <= w_operand;
              OP_INIT_ADDR: r_addr <= w_operand[ADDR_W-1:0];
              OP_ADD_ADDR:  r_addr <= r_addr + w_operand[ADDR_W-1:0];
              OP_LOAD:      r_lfsr <= r_mem[r_addr];
              OP_ST_AVG: begin
                // Snapshot so the division is independent of later changes.
                r_cnt <= 16'(CNT_W);
                r_quo <= r_hd_sum;
                r_rem <= '0;
                r_dsr <= r_shift_cnt;
              end
              OP_STORE, OP_ST_HD, OP_HALT: ;
              default:      r_illegal <= 1'b1;
            endcase
          end
        end
        S_RUN, S_BATCH: begin
          r_lfsr      <= w_next;
          r_last_hd   <= w_hd;
          r_hd_sum    <= sat_add(r_hd_sum, CNT_W'(w_hd));
          r_shift_cnt <= sat_add(r_shift_cnt, CNT_W'(1));
          r_cnt       <= r_cnt - 16'd1;
          if (r_state == S_BATCH) r_addr <= r_addr + ADDR_W'(1);
        end
        S_DIV: begin
          r_rem <= w_div_ge ? w_div_diff : w_div_shift[CNT_W-1:0];
          r_quo <= {r_quo[CNT_W-2:0], w_div_ge};
          r_cnt <= r_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // ---- Pattern RAM write port ----
  always_comb begin
    w_mem_we = 1'b0;
    w_mem_wd = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (w_opcode == OP_STORE)) begin
          w_mem_we = 1'b1;
          w_mem_wd = r_lfsr;
        end else if (w_accept && (w_opcode == OP_ST_HD)) begin
          w_mem_we = 1'b1;
          w_mem_wd = {{(WIDTH-HD_W){1'b0}}, r_last_hd};
        end
      end
      S_BATCH: begin
        w_mem_we = 1'b1;
        w_mem_wd = w_next;
      end
      S_WR: begin
        w_mem_we = 1'b1;
        w_mem_wd = w_avg;
      end
      default: ;
    endcase
    // The RAM has no reset; block writes while reset is held.
    if (rst) w_mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= w_mem_wd;
  end

  assign dbg_data  = r_mem[dbg_addr];
  assign lfsr_q    = r_lfsr;
  assign lfsr_next = w_next;
  assign addr      = r_addr;
  assign last_hd   = r_last_hd;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_lfsr_prpg_core.sv
// Scoreboard bench for lfsr_prpg_core (default parameters, WIDTH=8).
// Stimulus pushes expected values into queues; a monitor process pops
// and compares on falling clock edges.
module tb_lfsr_prpg_core;

  localparam int W  = 8;
  localparam int AW = 8;

  localparam logic [5:0] OP_CFG_TAP   = 6'h01;
  localparam logic [5:0] OP_INIT      = 6'h02;
  localparam logic [5:0] OP_RUN       = 6'h03;
  localparam logic [5:0] OP_STORE     = 6'h04;
  localparam logic [5:0] OP_LOAD      = 6'h05;
  localparam logic [5:0] OP_INIT_ADDR = 6'h06;
  localparam logic [5:0] OP_ADD_ADDR  = 6'h07;
  localparam logic [5:0] OP_CFG_MODE  = 6'h08;
  localparam logic [5:0] OP_ST_HD     = 6'h09;
  localparam logic [5:0] OP_ST_AVG    = 6'h0A;
  localparam logic [5:0] OP_BATCH     = 6'h0B;
  localparam logic [5:0] OP_HALT      = 6'h3F;

  localparam int SIG_LFSR  = 0;
  localparam int SIG_NEXT  = 1;
  localparam int SIG_ADDR  = 2;
  localparam int SIG_HD    = 3;
  localparam int SIG_READY = 4;
  localparam int SIG_BUSY  = 5;
  localparam int SIG_HALT  = 6;
  localparam int SIG_ILL   = 7;
  localparam int SIG_DBG   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instr_valid = 1'b0;
  logic [21:0]   instr = '0;
  logic          instr_ready;
  logic          busy;
  logic          halted;
  logic          illegal;
  logic [W-1:0]  lfsr_q;
  logic [W-1:0]  lfsr_next;
  logic [AW-1:0] addr;
  logic [3:0]    last_hd;
  logic [AW-1:0] dbg_addr = '0;
  logic [W-1:0]  dbg_data;

  always #5 clk = ~clk;

  lfsr_prpg_core dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .busy(busy), .halted(halted),
    .illegal(illegal), .lfsr_q(lfsr_q), .lfsr_next(lfsr_next),
    .addr(addr), .last_hd(last_hd), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  typedef struct {
    string name;
    int    sig;
    int    exp;
  } chk_t;

  chk_t q_chk[$];
  int   q_busy[$];
  int   tests = 0;
  int   fails = 0;

  function automatic int sample(input int sig);
    case (sig)
      SIG_LFSR:  return int'(lfsr_q);
      SIG_NEXT:  return int'(lfsr_next);
      SIG_ADDR:  return int'(addr);
      SIG_HD:    return int'(last_hd);
      SIG_READY: return int'(instr_ready);
      SIG_BUSY:  return int'(busy);
      SIG_HALT:  return int'(halted);
      SIG_ILL:   return int'(illegal);
      SIG_DBG:   return int'(dbg_data);
      default:   return -1;
    endcase
  endfunction

  // Monitor: measures every busy interval and drains pending checks.
  initial begin
    int   busy_len;
    chk_t c;
    int   act;
    int   exp_len;
    busy_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_len = 0;
      end else if (busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        tests++;
        if (q_busy.size() == 0) begin
          fails++;
          $display("FAIL busy_len: got %0d cycles, none expected", busy_len);
        end else begin
          exp_len = q_busy.pop_front();
          if (busy_len != exp_len) begin
            fails++;
            $display("FAIL busy_len: got %0d cycles, expected %0d", busy_len, exp_len);
          end
        end
        busy_len = 0;
      end
      while (q_chk.size() != 0) begin
        c = q_chk.pop_front();
        act = sample(c.sig);
        tests++;
        if (act != c.exp) begin
          fails++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int sig, input int exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    q_chk.push_back(c);
  endtask

  task automatic drain();
    int n = 0;
    while (q_chk.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q_chk.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d checks pending, expected 0", q_chk.size());
      q_chk.delete();
    end
  endtask

  task automatic mchk(input string name, input logic [AW-1:0] a, input int exp);
    dbg_addr = a;
    chk(name, SIG_DBG, exp);
    drain();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!instr_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!instr_ready) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: ready=%0d, expected 1", instr_ready);
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [15:0] opd);
    wait_idle();
    instr_valid = 1'b1;
    instr       = {op, opd};
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_lfsr", SIG_LFSR, 'h01);
    chk("rst_next", SIG_NEXT, 'h02);
    chk("rst_addr", SIG_ADDR, 0);
    chk("rst_hd", SIG_HD, 0);
    chk("rst_busy", SIG_BUSY, 0);
    chk("rst_halt", SIG_HALT, 0);
    chk("rst_ill", SIG_ILL, 0);
    chk("rst_ready", SIG_READY, 1);
    drain();

    // Galois, tap 0x1D
    send(OP_CFG_TAP, 16'h001D);
    send(OP_CFG_MODE, 16'h0000);
    send(OP_INIT, 16'h0080);
    chk("gal_next80", SIG_NEXT, 'h1D);
    drain();
    q_busy.push_back(1);
    send(OP_RUN, 16'd1);
    wait_idle();
    chk("gal_run1", SIG_LFSR, 'h1D);
    chk("gal_hd", SIG_HD, 5);
    drain();
    send(OP_INIT_ADDR, 16'h0020);
    send(OP_ST_HD, 16'h0000);
    send(OP_ADD_ADDR, 16'h0001);
    send(OP_STORE, 16'h0000);
    wait_idle();
    chk("addr_21", SIG_ADDR, 'h21);
    drain();
    mchk("st_hd_mem20", 8'h20, 5);
    mchk("store_mem21", 8'h21, 'h1D);
    send(OP_INIT, 16'h0080);
    q_busy.push_back(2);
    send(OP_RUN, 16'd2);
    wait_idle();
    chk("gal_run2", SIG_LFSR, 'h3A);
    chk("gal_run2_hd", SIG_HD, 4);
    drain();

    // Fibonacci, tap 0xB8
    send(OP_CFG_TAP, 16'h00B8);
    send(OP_CFG_MODE, 16'h0001);
    send(OP_INIT, 16'h0001);
    chk("fib_next01", SIG_NEXT, 'h02);
    drain();
    q_busy.push_back(1);
    send(OP_RUN, 16'd1);
    wait_idle();
    chk("fib_run01", SIG_LFSR, 'h02);
    chk("fib_hd01", SIG_HD, 2);
    drain();
    send(OP_INIT, 16'h0080);
    chk("fib_next80", SIG_NEXT, 'h01);
    chk("init_clr_hd", SIG_HD, 0);
    drain();
    q_busy.push_back(1);
    send(OP_RUN, 16'd1);
    wait_idle();
    chk("fib_run80", SIG_LFSR, 'h01);
    drain();
    send(OP_LOAD, 16'h0000);
    wait_idle();
    chk("load_lfsr", SIG_LFSR, 'h1D);
    chk("load_hd_kept", SIG_HD, 2);
    drain();

    // RUN 0 is a no-op without busy
    send(OP_RUN, 16'd0);
    wait_idle();
    chk("run0_lfsr", SIG_LFSR, 'h1D);
    drain();

    // BATCH capture and average
    send(OP_CFG_MODE, 16'h0000);
    send(OP_CFG_TAP, 16'h001D);
    send(OP_INIT, 16'h0001);
    send(OP_INIT_ADDR, 16'h0010);
    q_busy.push_back(3);
    send(OP_BATCH, 16'd3);
    wait_idle();
    chk("batch_addr", SIG_ADDR, 'h13);
    chk("batch_lfsr", SIG_LFSR, 'h08);
    drain();
    mchk("batch_m10", 8'h10, 'h02);
    mchk("batch_m11", 8'h11, 'h04);
    mchk("batch_m12", 8'h12, 'h08);
    q_busy.push_back(25);
    send(OP_ST_AVG, 16'h0000);
    wait_idle();
    mchk("avg_m13", 8'h13, 2);
    chk("avg_addr", SIG_ADDR, 'h13);
    drain();

    // Average with zero shift count
    send(OP_INIT, 16'h0055);
    send(OP_INIT_ADDR, 16'h0030);
    send(OP_STORE, 16'h0000);
    wait_idle();
    mchk("pre_avg0_m30", 8'h30, 'h55);
    q_busy.push_back(25);
    send(OP_ST_AVG, 16'h0000);
    wait_idle();
    mchk("avg0_m30", 8'h30, 0);

    // Address wrap
    send(OP_INIT, 16'h0001);
    send(OP_INIT_ADDR, 16'h00FF);
    q_busy.push_back(2);
    send(OP_BATCH, 16'd2);
    wait_idle();
    chk("wrap_addr", SIG_ADDR, 'h01);
    drain();
    mchk("wrap_mFF", 8'hFF, 'h02);
    mchk("wrap_m00", 8'h00, 'h04);
    send(OP_ADD_ADDR, 16'h01FF);
    wait_idle();
    chk("add_addr_wrap", SIG_ADDR, 0);
    drain();

    // Reset in the middle of BATCH 100, after 40 shifts
    send(OP_INIT, 16'h00A5);
    send(OP_INIT_ADDR, 16'h0068);
    send(OP_STORE, 16'h0000);
    send(OP_ADD_ADDR, 16'h0001);
    send(OP_STORE, 16'h0000);
    send(OP_INIT, 16'h0001);
    send(OP_INIT_ADDR, 16'h0040);
    send(OP_BATCH, 16'd100);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("abort_lfsr", SIG_LFSR, 'h01);
    chk("abort_addr", SIG_ADDR, 0);
    chk("abort_hd", SIG_HD, 0);
    chk("abort_busy", SIG_BUSY, 0);
    drain();
    mchk("abort_m40", 8'h40, 'h02);
    mchk("abort_m68", 8'h68, 'hA5);
    mchk("abort_m69", 8'h69, 'hA5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("release_ready", SIG_READY, 1);
    instr_valid = 1'b1;
    instr       = {OP_INIT, 16'h0033};
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("first_accept", SIG_LFSR, 'h33);
    drain();

    // Illegal opcode
    send(6'h2A, 16'h1234);
    wait_idle();
    chk("ill_flag", SIG_ILL, 1);
    chk("ill_lfsr", SIG_LFSR, 'h33);
    chk("ill_addr", SIG_ADDR, 0);
    chk("ill_ready", SIG_READY, 1);
    drain();

    // HALT with an instruction held valid for 20 cycles
    instr_valid = 1'b1;
    instr       = {OP_HALT, 16'h0000};
    @(posedge clk);
    #1;
    instr = {OP_INIT, 16'h0077};
    chk("halt_flag", SIG_HALT, 1);
    chk("halt_ready", SIG_READY, 0);
    drain();
    repeat (20) @(posedge clk);
    #1;
    chk("halt_hold_lfsr", SIG_LFSR, 'h33);
    chk("halt_hold_ready", SIG_READY, 0);
    drain();
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_halt_ready", SIG_READY, 1);
    chk("post_halt_ill", SIG_ILL, 0);
    chk("post_halt_halt", SIG_HALT, 0);
    chk("post_halt_lfsr", SIG_LFSR, 'h01);
    drain();

    repeat (2) @(negedge clk);
    tests++;
    if (q_busy.size() != 0) begin
      fails++;
      $display("FAIL busy_pending: %0d busy intervals unseen, expected 0", q_busy.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
